// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand/opcode request channel and
// result/flags response channel, plus the multiplier busy indication.
// The producer/consumer side uses the master modport; the ALU uses slave.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inOne;
    logic [WIDTH-1:0] inTwo;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, inOne, inTwo, opcode, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, inOne, inTwo, opcode, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute ALU with a registered result/flags slot.
// Single-cycle ops (add/sub/logic/move/shift) complete on the accepting edge.
// Optional feature macro ALU_MUL_EN: when defined, opcode 1110 runs an
// iterative shift-add multiplier retiring MUL_STEP bits per cycle and the
// unit reports busy; when undefined, 1110 is treated as an undefined opcode.
// Flags are {N,Z,C,V}. The bus interface WIDTH must match this WIDTH.
module alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b1010;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b1100;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MOV   = 4'b1101;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_LSR   = 4'b1000;

    // Parameter sanity checks at elaboration time
    if (WIDTH < 8) begin : g_width_chk
        $error("alu_pipe: WIDTH must be >= 8");
    end
    if ((MUL_STEP < 1) || ((WIDTH % MUL_STEP) != 0)) begin : g_step_chk
        $error("alu_pipe: MUL_STEP must divide WIDTH");
    end

    // Shared control/datapath signals
    logic             in_ready_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_sum_s;

    // Single-cycle datapath signals
    logic [SHW-1:0]   sh_amt_s;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [3:0]       alu_flags_s;

    // Output slot registers
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;

    assign sh_amt_s = bus.inTwo[SHW-1:0];

    // Single-cycle operation result and carry/overflow for the presented operands
    always_comb begin
        ext_s     = '0;
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                ext_s     = {1'b0, bus.inOne} + {1'b0, bus.inTwo};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_c_s   = ext_s[WIDTH];
                alu_v_s   = (bus.inOne[WIDTH-1] == bus.inTwo[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != bus.inOne[WIDTH-1]);
            end
            OP_SUB: begin
                // A + ~B + 1: carry-out set means no borrow (A >= B unsigned)
                ext_s     = {1'b0, bus.inOne} + {1'b0, ~bus.inTwo} + {{WIDTH{1'b0}}, 1'b1};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_c_s   = ext_s[WIDTH];
                alu_v_s   = (bus.inOne[WIDTH-1] != bus.inTwo[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != bus.inOne[WIDTH-1]);
            end
            OP_AND:   alu_res_s = bus.inOne & bus.inTwo;
            OP_OR:    alu_res_s = bus.inOne | bus.inTwo;
            OP_XOR:   alu_res_s = bus.inOne ^ bus.inTwo;
            OP_NOR:   alu_res_s = ~(bus.inOne | bus.inTwo);
            OP_NAND:  alu_res_s = ~(bus.inOne & bus.inTwo);
            OP_PASSB: alu_res_s = bus.inTwo;
            OP_MOV:   alu_res_s = bus.inOne;
            OP_LSL: begin
                // Extra top bit catches the last bit shifted out; zero for amount 0
                ext_s     = {1'b0, bus.inOne} << sh_amt_s;
                alu_res_s = ext_s[WIDTH-1:0];
                alu_c_s   = ext_s[WIDTH];
            end
            OP_LSR: begin
                // Extra bottom bit catches the last bit shifted out; zero for amount 0
                ext_s     = {bus.inOne, 1'b0} >> sh_amt_s;
                alu_res_s = ext_s[WIDTH:1];
                alu_c_s   = ext_s[0];
            end
            default: begin
                alu_res_s = '0;
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
        alu_flags_s = {alu_res_s[WIDTH-1], (alu_res_s == '0), alu_c_s, alu_v_s};
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_r;
    logic             drain_ok_s;
    logic             last_step_s;
    logic             step_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] part_s;

    assign is_mul_s = (bus.opcode == OP_MUL);
    assign bus.busy = busy_r;

    // FSM state register; busy mirrors the registered state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_MUL);
        end
    end

    // FSM next state: enter MUL on a multiply accept, leave when the last step retires
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: acceptance gating and multiplier step strobes
    always_comb begin
        drain_ok_s  = !out_valid_r || bus.out_ready;
        in_ready_s  = reset_n && (state_r == ST_IDLE) && drain_ok_s;
        accept_s    = bus.in_valid && in_ready_s;
        last_step_s = (count_r == CW'(STEPS - 1));
        // The final step only retires once the output slot can take the product
        if (state_r == ST_MUL) begin
            step_s     = !last_step_s || drain_ok_s;
            mul_done_s = last_step_s && drain_ok_s;
        end else begin
            step_s     = 1'b0;
            mul_done_s = 1'b0;
        end
    end

    // Partial product for the MUL_STEP multiplier bits retired this cycle
    always_comb begin
        part_s = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_r[j]) begin
                part_s = part_s + (mcand_r << j);
            end else begin
                part_s = part_s;
            end
        end
        mul_sum_s = acc_r + part_s;
    end

    // Multiplier operands/accumulator: latch on accept, advance one step per MUL cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_r  <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if (accept_s && is_mul_s) begin
            count_r  <= '0;
            mcand_r  <= bus.inOne;
            mplier_r <= bus.inTwo;
            acc_r    <= '0;
        end else if (step_s) begin
            count_r  <= count_r + CW'(1);
            mcand_r  <= mcand_r << MUL_STEP;
            mplier_r <= mplier_r >> MUL_STEP;
            acc_r    <= mul_sum_s;
        end else begin
            count_r  <= count_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end
`else
    assign is_mul_s   = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_sum_s  = '0;
    assign bus.busy   = 1'b0;

    // Without the multiplier only the output slot gates acceptance
    always_comb begin
        in_ready_s = reset_n && (!out_valid_r || bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;
    end
`endif

    // Output slot: load on single-cycle accept or multiply completion, clear once consumed
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            flags_r     <= 4'b0000;
        end else if (accept_s && !is_mul_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            flags_r     <= alu_flags_s;
        end else if (mul_done_s) begin
            out_valid_r <= 1'b1;
            result_r    <= mul_sum_s;
            flags_r     <= {mul_sum_s[WIDTH-1], (mul_sum_s == '0), 1'b0, 1'b0};
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            result_r    <= result_r;
            flags_r     <= flags_r;
        end else begin
            out_valid_r <= out_valid_r;
            result_r    <= result_r;
            flags_r     <= flags_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32, MUL_STEP=1): directed vectors,
// back-pressure, a scoreboarded back-to-back run, and multiplier checks when
// ALU_MUL_EN is defined (undefined-opcode checks otherwise).
module tb_alu_pipe;
    localparam int W = 32;
    localparam int TB_MUL_STEP = 1;

    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b1010, AND_ = 4'b0110, OR_ = 4'b0100;
    localparam logic [3:0] XOR_ = 4'b1001, NOR_ = 4'b0101, NAND_ = 4'b1100, PASSB = 4'b0111;
    localparam logic [3:0] MOV = 4'b1101, LSL = 4'b0011, LSR = 4'b1000, MUL = 4'b1110;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W), .MUL_STEP(TB_MUL_STEP)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs [18];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one op, wait (bounded) for in_ready, then complete the transfer edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int waited;
        waited = 0;
        bus.inOne    = a;
        bus.inTwo    = b;
        bus.opcode   = op;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) check_val("accept_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Reference model: returns {N,Z,C,V,result}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] r;
        logic [32:0] t;
        logic        c;
        logic        v;
        int          sh;
        r = 32'd0; c = 1'b0; v = 1'b0; sh = int'(b[4:0]);
        case (op)
            ADD: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            AND_:  r = a & b;
            OR_:   r = a | b;
            XOR_:  r = a ^ b;
            NOR_:  r = ~(a | b);
            NAND_: r = ~(a & b);
            PASSB: r = b;
            MOV:   r = a;
            LSL: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[32 - sh];
            end
            LSR: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    logic [35:0] q [$];
    logic [35:0] e;
    int          accepted;
    int          popped;
    int          cyc;
    logic [3:0]  rop;

    initial begin
        n_total = 0;
        n_bad   = 0;
        vecs[0]  = '{ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
        vecs[1]  = '{ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
        vecs[2]  = '{SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{SUB,   32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 4'b0010};
        vecs[4]  = '{LSL,   32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010};
        vecs[5]  = '{LSR,   32'h8000_0001, 32'h0000_0021, 32'h4000_0000, 4'b0010};
        vecs[6]  = '{AND_,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
        vecs[7]  = '{OR_,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000};
        vecs[8]  = '{XOR_,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b0100};
        vecs[9]  = '{NOR_,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
        vecs[10] = '{NAND_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100};
        vecs[11] = '{PASSB, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678, 4'b0000};
        vecs[12] = '{MOV,   32'h8000_0000, 32'h0000_0005, 32'h8000_0000, 4'b1000};
        vecs[13] = '{LSL,   32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 4'b1000};
        vecs[14] = '{SUB,   32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
        vecs[15] = '{LSR,   32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0110};
        vecs[16] = '{NOR_,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 4'b0100};
        vecs[17] = '{4'b1111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 4'b0100};

        // Reset
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.inOne = 32'd0; bus.inTwo = 32'd0; bus.opcode = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_result",    64'(bus.result),    64'd0);
        check_val("rst_flags",     64'(bus.flags),     64'd0);
        check_val("rst_busy",      64'(bus.busy),      64'd0);
        check_val("rst_in_ready",  64'(bus.in_ready),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single-cycle ops, back to back, latency 1
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op);
            check_val($sformatf("v%0d_valid", i),  64'(bus.out_valid), 64'd1);
            check_val($sformatf("v%0d_result", i), 64'(bus.result),    64'(vecs[i].r));
            check_val($sformatf("v%0d_flags", i),  64'(bus.flags),     64'(vecs[i].f));
        end

`ifndef ALU_MUL_EN
        // 1110 is an undefined opcode in this build
        send(32'd3, 32'd4, MUL);
        check_val("nomul_valid",  64'(bus.out_valid), 64'd1);
        check_val("nomul_result", 64'(bus.result),    64'd0);
        check_val("nomul_flags",  64'(bus.flags),     64'(4'b0100));
        check_val("nomul_busy",   64'(bus.busy),      64'd0);
`endif

        // Back-pressure: ADD 1+2 held for 3 cycles while the next op waits
        send(32'd1, 32'd2, ADD);
        bus.out_ready = 1'b0;
        check_val("bp_first", 64'(bus.result), 64'd3);
        bus.inOne = 32'd10; bus.inTwo = 32'd4; bus.opcode = SUB; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("bp_hold%0d_result", k), 64'(bus.result),    64'd3);
            check_val($sformatf("bp_hold%0d_valid", k),  64'(bus.out_valid), 64'd1);
            check_val($sformatf("bp_hold%0d_inrdy", k),  64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_inrdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_val("bp_next_result", 64'(bus.result),    64'd6);
        check_val("bp_next_valid",  64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        check_val("bp_drained", 64'(bus.out_valid), 64'd0);

        // Scoreboarded random run: 100 accepted ops with random valid/ready
        accepted = 0; popped = 0; cyc = 0;
        while (accepted < 100 && cyc < 3000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            rop = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (rop == MUL) rop = ADD;
`endif
            bus.opcode = rop;
            bus.inOne  = $urandom;
            bus.inTwo  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check_val("rnd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    popped++;
                    check_val($sformatf("rnd%0d", popped), 64'({bus.flags, bus.result}), 64'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.inOne, bus.inTwo, bus.opcode));
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check_val("rnd_dup", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    popped++;
                    check_val($sformatf("rnd%0d", popped), 64'({bus.flags, bus.result}), 64'(e));
                end
            end
            @(posedge clk); #1;
        end
        check_val("rnd_popped", 64'(popped), 64'd100);
        check_val("rnd_left",   64'(q.size()), 64'd0);

`ifdef ALU_MUL_EN
        // Iterative multiply: latency WIDTH/MUL_STEP, busy while running
        send(32'h0001_0000, 32'h0001_0001, MUL);
        check_val("mul_busy",   64'(bus.busy),      64'd1);
        check_val("mul_inrdy",  64'(bus.in_ready),  64'd0);
        check_val("mul_nvalid", 64'(bus.out_valid), 64'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("mul_latency", 64'(cyc), 64'(W / TB_MUL_STEP));
        check_val("mul_result",  64'(bus.result), 64'h0001_0000);
        check_val("mul_flags",   64'(bus.flags),  64'd0);
        check_val("mul_busy_end", 64'(bus.busy),  64'd0);
        @(posedge clk); #1;

        // Reset during multiply cycle 10 abandons it
        send(32'h0001_0000, 32'h0001_0001, MUL);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("mulrst_busy",  64'(bus.busy),      64'd0);
        check_val("mulrst_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check_val("mulrst_novalid", 64'(bus.out_valid), 64'd0);
        send(32'd1, 32'd1, ADD);
        check_val("mulrst_add", 64'(bus.result), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
